writeback_queue: RTL
====================

Name: writeback_queue

Overview:
- Writer-side companion to the register file. It collects results from the ALU and memory result buses and buffers them in a small FIFO.
- It drives the register file's single write port, retiring at most one entry per clock.
- It also tells decode whether a source register still has a write in flight (pending), so decode can stall.

Parameters:
- d_width, 16, data width; must match the register file data width.
- a_width, 3, register address width.
- q_width, 2, queue address width; depth = 2**q_width entries, and q_width >= 1.

Ports:
- clk  input  1  clock, posedge.
- clr  input  1  reset; asynchronous, active-low.
- mem_valid  input  1  memory result present this cycle.
- mem_addr  input  a_width  destination register for the memory result.
- mem_data  input  d_width  memory result data.
- mem_ready  output  1  memory result is accepted at this edge when mem_valid=1.
- alu_valid  input  1  ALU result present this cycle.
- alu_addr  input  a_width  destination register for the ALU result.
- alu_data  input  d_width  ALU result data.
- alu_ready  output  1  ALU result is accepted at this edge when alu_valid=1.
- write  output  1  register file write enable.
- writeaddr  output  a_width  register file write address.
- data_out  output  d_width  register file write data.
- chk0addr  input  a_width  decode source-0 address.
- chk1addr  input  a_width  decode source-1 address.
- pend0  output  1  some queued entry targets chk0addr.
- pend1  output  1  some queued entry targets chk1addr.
- count  output  q_width+1  number of queued entries.

Behaviour:
- Reset: clr=0 clears head, tail and count asynchronously. While in reset and after release until the first accept: write=0, writeaddr=0, data_out=0, pend0=pend1=0, count=0, both readies=1.
- Retire:
  - write = (count!=0); writeaddr and data_out are driven combinationally from the head entry.
  - When count=0, writeaddr=0 and data_out=0.
  - The head is popped at every posedge where count!=0. There is no back-pressure from the register file.
- Free space: free = 2**q_width - count + (count!=0 ? 1 : 0). The pop performed at an edge frees its slot for a push at the same edge.
- Readiness and priority (memory has priority):
  - mem_ready = (free>=1).
  - alu_ready = (free>=2) | (free>=1 & !mem_valid).
  - Readies are combinational from state and mem_valid; they do not depend on alu_valid.
- Push:
  - A source is accepted when valid & ready.
  - If both sources are accepted at the same edge, the memory entry is written at tail and the ALU entry at tail+1, so memory retires first.
  - tail advances by the number of accepted entries (0, 1 or 2) and wraps modulo depth.
  - count_next = count + pushes - pop.
- Latency: an entry pushed at edge N into an empty queue gives write=1 during cycle N..N+1, and the register file captures it at edge N+1.
- Ordering: entries retire strictly in push order. Two pending writes to the same register therefore resolve to the younger one.
- Pending:
  - pendX=1 iff any valid entry, including the head being retired this cycle, has address == chkXaddr.
  - The check is purely combinational, with no compare against same-cycle inputs on mem_* or alu_*.
- Full: when count = depth and no pop occurs, both readies=0. This cannot happen while count!=0, because a pop always occurs then; full therefore only limits accepts to one slot.
- Wrap: head and tail pointers wrap silently at depth; count distinguishes full from empty.
- Reset mid-operation: all queued entries are discarded immediately and write drops to 0 asynchronously.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- When defined, add outputs fwd0_data and fwd1_data (d_width each). Each carries the data of the youngest queued entry whose address matches chkXaddr, or 0 if there is no match. Decode uses these to forward instead of stalling.
- When not defined, these ports and their match logic are absent; pend0 and pend1 are unchanged.

Test Plan:
- Reset: drive clr=0 mid-stream with 3 entries queued -> write=0, count=0, pend0=pend1=0 immediately; after release the first push behaves as from empty.
- Single ALU push of addr=5, data=0x1234 into an empty queue -> next cycle write=1, writeaddr=5, data_out=0x1234; register 5 holds 0x1234 one edge later; count returns to 0.
- Dual push mem(addr=2, 0xAAAA) + alu(addr=3, 0xBBBB) with count=0 -> both accepted, count=2; retire order is reg2 then reg3 on consecutive cycles.
- Priority at near-full: depth 4, count=4, both valid -> free=1, mem accepted, alu_ready=0; count stays 4 after the edge (push 1, pop 1).
- Pending and order: push alu addr=1 data=0x0001, then mem addr=1 data=0x0002, then check chk0addr=1 -> pend0=1 for two cycles; reg1 ends at 0x0002. With WBQ_BYPASS_EN, fwd0_data=0x0002 while both entries are queued.
- Wrap: stream 10 single pushes of addr=i, data=i with depth 4 -> every entry is retired once, in order, with no loss; count never exceeds 2.

Source files
------------

// File: rtl/writeback_queue.sv
// Write-back queue: buffers ALU and memory results and retires one per clock into the register
// file write port. Define WBQ_BYPASS_EN to add per-source youngest-match forwarding data.
module writeback_queue #(
    parameter int unsigned d_width = 16,
    parameter int unsigned a_width = 3,
    parameter int unsigned q_width = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               mem_valid,
    input  logic [a_width-1:0] mem_addr,
    input  logic [d_width-1:0] mem_data,
    output logic               mem_ready,
    input  logic               alu_valid,
    input  logic [a_width-1:0] alu_addr,
    input  logic [d_width-1:0] alu_data,
    output logic               alu_ready,
    output logic               write,
    output logic [a_width-1:0] writeaddr,
    output logic [d_width-1:0] data_out,
    input  logic [a_width-1:0] chk0addr,
    input  logic [a_width-1:0] chk1addr,
    output logic               pend0,
    output logic               pend1,
`ifdef WBQ_BYPASS_EN
    output logic [d_width-1:0] fwd0_data,
    output logic [d_width-1:0] fwd1_data,
`endif
    output logic [q_width:0]   count
);

    localparam int unsigned depth = 2 ** q_width;
    localparam logic [q_width+1:0] DepthW  = (q_width + 2)'(depth);
    localparam logic [q_width+1:0] FreeOne = (q_width + 2)'(1);
    localparam logic [q_width+1:0] FreeTwo = (q_width + 2)'(2);

    logic [a_width-1:0] addr_q [depth];
    logic [d_width-1:0] data_q [depth];
    logic [q_width-1:0] head_q, tail_q, tail_d, alu_slot;
    logic [q_width:0]   count_q, count_d;
    logic [q_width+1:0] free;
    logic               pop, mem_acc, alu_acc;

    // Slot index and liveness of each entry, ordered oldest (age 0) to youngest.
    logic [q_width-1:0] age_slot [depth];
    logic [depth-1:0]   age_live;

    assign pop  = (count_q != '0);
    // The slot popped at this edge can be refilled at the same edge.
    assign free = DepthW - {1'b0, count_q} + {{(q_width + 1){1'b0}}, pop};

    assign mem_ready = (free >= FreeOne);
    assign alu_ready = (free >= FreeTwo) | ((free >= FreeOne) & ~mem_valid);

    assign mem_acc  = mem_valid & mem_ready;
    assign alu_acc  = alu_valid & alu_ready;
    assign alu_slot = tail_q + q_width'(mem_acc);

    always_comb begin
        tail_d  = tail_q + q_width'(mem_acc) + q_width'(alu_acc);
        count_d = count_q + (q_width + 1)'(mem_acc) + (q_width + 1)'(alu_acc)
                  - (q_width + 1)'(pop);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + q_width'(pop);
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; liveness is tracked by head/count.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            addr_q[tail_q] <= mem_addr;
            data_q[tail_q] <= mem_data;
        end
        if (alu_acc) begin
            addr_q[alu_slot] <= alu_addr;
            data_q[alu_slot] <= alu_data;
        end
    end

    assign write     = pop;
    assign writeaddr = pop ? addr_q[head_q] : '0;
    assign data_out  = pop ? data_q[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        for (int unsigned k = 0; k < depth; k++) begin
            age_slot[k] = head_q + q_width'(k);
            age_live[k] = ((q_width + 1)'(k) < count_q);
        end
    end

    always_comb begin
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int unsigned k = 0; k < depth; k++) begin
            if (age_live[k] && (addr_q[age_slot[k]] == chk0addr)) pend0 = 1'b1;
            if (age_live[k] && (addr_q[age_slot[k]] == chk1addr)) pend1 = 1'b1;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd0_data = '0;
        fwd1_data = '0;
        for (int unsigned k = 0; k < depth; k++) begin
            if (age_live[k] && (addr_q[age_slot[k]] == chk0addr)) fwd0_data = data_q[age_slot[k]];
            if (age_live[k] && (addr_q[age_slot[k]] == chk1addr)) fwd1_data = data_q[age_slot[k]];
        end
    end
`endif

endmodule
